// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 encrypt/decrypt engine with in-place key expansion.
// Latency: key expansion 4(Nr+1)-Nk cycles; out_valid rises Nr+1 edges after block accept.
// Backpressure: result held in DONE until out_ready; no key or block accepted meanwhile.
// Optional feature macro: AES_BLOCK_COUNT_EN adds a 32-bit block_count output.
module aes_iter_core #(
  parameter int Nk = 8,
  parameter int Nr = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [32*Nk-1:0]  Key,
  input  logic              key_load,
  output logic              key_ready,
  input  logic [127:0]      Text,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [127:0]      OutText,
  output logic              out_valid,
  input  logic              out_ready
`ifdef AES_BLOCK_COUNT_EN
  ,
  output logic [31:0]       block_count
`endif
);

  localparam int NW = 4 * (Nr + 1);
  localparam int KW = 32 * Nk;

  generate
    if (!((Nk == 4 || Nk == 6 || Nk == 8) && Nr == Nk + 6)) begin : g_cfg_check
      $error("aes_iter_core: Nk must be 4, 6 or 8 and Nr must equal Nk+6");
    end
  endgenerate

  typedef enum logic [2:0] {NOKEY, EXPAND, IDLE, RUN, DONE} state_e;
  // byte 0 of the AES state is element 0 (most significant byte)
  typedef logic [0:15][7:0] blk_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // multiplicative inverse as a^254 (maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic blk_t sub_bytes(input blk_t b, input logic inv);
    blk_t o;
    for (int k = 0; k < 16; k++) o[k] = inv ? isbox(b[k]) : sbox(b[k]);
    return o;
  endfunction

  // row r of column c lives in byte 4c+r
  function automatic blk_t shift_rows(input blk_t b, input logic inv);
    blk_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (inv) o[4*c+r] = b[4*((c+4-r)%4)+r];
        else     o[4*c+r] = b[4*((c+r)%4)+r];
      end
    end
    return o;
  endfunction

  function automatic blk_t mix_cols(input blk_t b, input logic inv);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
      if (!inv) begin
        o[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        o[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        o[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        o[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end else begin
        o[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        o[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        o[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        o[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    return o;
  endfunction

  // ports carry bit 0 = MSB of byte 0; internally the conventional order is used
  function automatic logic [127:0] rev128(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [5:0]    wcnt_q, wcnt_d;
  logic [2:0]    kidx_q, kidx_d;
  logic [7:0]    rcon_q, rcon_d;
  blk_t          st_q, st_d;
  logic          mode_q, mode_d;
  logic [127:0]  out_q, out_d;
  logic          ov_q, ov_d;
  logic [31:0]   kw_q [0:NW-1];
`ifdef AES_BLOCK_COUNT_EN
  logic [31:0]   bc_q, bc_d;
`endif

  logic          key_acc;
  logic          kw_we;
  logic [KW-1:0] key_std;
  blk_t          text_std;
  logic [3:0]    rk_idx;
  blk_t          rk;
  blk_t          round_out;
  logic [31:0]   w_prev, w_old, w_tmp, w_new;

  assign key_ready = (state_q == NOKEY) || (state_q == IDLE);
  assign in_ready  = (state_q == IDLE) && !key_load;
  assign key_acc   = key_ready && key_load;
  assign OutText   = out_q;
  assign out_valid = ov_q;
`ifdef AES_BLOCK_COUNT_EN
  assign block_count = bc_q;
`endif

  // reorder port bits into conventional byte order
  always_comb begin
    key_std = '0;
    for (int i = 0; i < KW; i++) key_std[i] = Key[KW-1-i];
    text_std = rev128(Text);
  end

  // round-key select: rk[0]/rk[Nr] at accept, then rk[r] or rk[Nr-r] while running
  always_comb begin
    rk_idx = rnd_q;
    if (state_q == IDLE)         rk_idx = mode ? 4'(Nr) : 4'd0;
    else if (rnd_q > 4'(Nr))     rk_idx = 4'd0;
    else if (mode_q)             rk_idx = 4'(Nr) - rnd_q;
    rk = {kw_q[{rk_idx, 2'd0}], kw_q[{rk_idx, 2'd1}], kw_q[{rk_idx, 2'd2}], kw_q[{rk_idx, 2'd3}]};
  end

  // one cipher or inverse-cipher round; the final round skips (Inv)MixColumns
  always_comb begin
    round_out = st_q;
    if (!mode_q) begin
      round_out = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
      if (rnd_q != 4'(Nr)) round_out = mix_cols(round_out, 1'b0);
      round_out = round_out ^ rk;
    end else begin
      round_out = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ rk;
      if (rnd_q != 4'(Nr)) round_out = mix_cols(round_out, 1'b1);
    end
  end

  // next expanded key word w[i] from w[i-1] and w[i-Nk]; kidx tracks i mod Nk
  always_comb begin
    w_prev = kw_q[wcnt_q - 6'd1];
    w_old  = kw_q[wcnt_q - 6'(Nk)];
    w_tmp  = w_prev;
    if (kidx_q == 3'd0)
      w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h000000};
    else if (Nk == 8 && kidx_q == 3'd4)
      w_tmp = sub_word(w_prev);
    w_new = w_old ^ w_tmp;
  end

  // FSM next state and datapath register updates
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    wcnt_d  = wcnt_q;
    kidx_d  = kidx_q;
    rcon_d  = rcon_q;
    st_d    = st_q;
    mode_d  = mode_q;
    out_d   = out_q;
    ov_d    = ov_q;
    kw_we   = 1'b0;
`ifdef AES_BLOCK_COUNT_EN
    bc_d    = bc_q;
`endif
    case (state_q)
      NOKEY, IDLE: begin
        if (key_acc) begin
          state_d = EXPAND;
          wcnt_d  = 6'(Nk);
          kidx_d  = 3'd0;
          rcon_d  = 8'h01;
        end else if (state_q == IDLE && in_valid) begin
          mode_d  = mode;
          st_d    = text_std ^ rk;
          rnd_d   = 4'd1;
          state_d = RUN;
        end
      end
      EXPAND: begin
        kw_we  = 1'b1;
        wcnt_d = wcnt_q + 6'd1;
        kidx_d = (kidx_q == 3'(Nk-1)) ? 3'd0 : kidx_q + 3'd1;
        if (kidx_q == 3'd0) rcon_d = xt(rcon_q);
        if (wcnt_q == 6'(NW-1)) state_d = IDLE;
      end
      RUN: begin
        // rounds 1..Nr, then one cycle moving the final state into the output register
        if (rnd_q <= 4'(Nr)) begin
          st_d  = round_out;
          rnd_d = rnd_q + 4'd1;
        end else begin
          out_d   = rev128(st_q);
          ov_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
`ifdef AES_BLOCK_COUNT_EN
          bc_d    = bc_q + 32'd1;
`endif
        end
      end
      default: state_d = NOKEY;
    endcase
  end

  // control and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NOKEY;
      rnd_q   <= 4'd0;
      wcnt_q  <= 6'd0;
      kidx_q  <= 3'd0;
      rcon_q  <= 8'h00;
      st_q    <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
`ifdef AES_BLOCK_COUNT_EN
      bc_q    <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      wcnt_q  <= wcnt_d;
      kidx_q  <= kidx_d;
      rcon_q  <= rcon_d;
      st_q    <= st_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
`ifdef AES_BLOCK_COUNT_EN
      bc_q    <= bc_d;
`endif
    end
  end

  // expanded-key store: cipher key on load, one derived word per EXPAND cycle; never cleared
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (key_acc) begin
        for (int j = 0; j < Nk; j++) kw_q[j] <= key_std[32*(Nk-1-j) +: 32];
      end else if (kw_we) begin
        kw_q[wcnt_q] <= w_new;
      end
    end
  end

endmodule
